// File: rtl/ram_wr_port_scheduler.sv
// ram_wr_port_scheduler: per-requester FIFOs feeding NUM_WR_PORTS one-hot RAM write ports, round-robin with address-conflict skip.
// Optional perf counters (grant/stall/conflict) enabled by defining RAM_WR_SCHED_PERF_EN.
module ram_wr_port_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int NUM_WR_PORTS = 2,
  parameter int DEPTH        = 32,
  parameter int INDEX        = 5,
  parameter int WIDTH        = 32,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_REQ-1:0]                     reqValid_i,
  input  logic [NUM_REQ-1:0][INDEX-1:0]          reqAddr_i,
  input  logic [NUM_REQ-1:0][WIDTH-1:0]          reqData_i,
  output logic [NUM_REQ-1:0]                     reqReady_o,
  input  logic                                   ramReady_i,
  input  logic                                   ramGated_i,
  output logic [NUM_WR_PORTS-1:0][DEPTH-1:0]     addrWr_o,
  output logic [NUM_WR_PORTS-1:0][WIDTH-1:0]     dataWr_o,
  output logic [NUM_WR_PORTS-1:0]                wrEn_o,
`ifdef RAM_WR_SCHED_PERF_EN
  output logic [15:0]                            grantCnt_o,
  output logic [15:0]                            stallCnt_o,
  output logic [15:0]                            conflictCnt_o,
`endif
  output logic                                   idle_o
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int RW = $clog2(NUM_REQ);
  logic [INDEX-1:0]   addr_q [NUM_REQ][FIFO_DEPTH];
  logic [WIDTH-1:0]   data_q [NUM_REQ][FIFO_DEPTH];
  logic [PW-1:0]      wp_q [NUM_REQ];
  logic [PW-1:0]      rp_q [NUM_REQ];
  logic [CW-1:0]      cnt_q [NUM_REQ];
  logic [RW-1:0]      rr_q, rr_d, last;
  logic [NUM_REQ-1:0] push, pop, nempty;
  logic [DEPTH-1:0]   used;
  logic               run;
  int                 np, idx;
`ifdef RAM_WR_SCHED_PERF_EN
  int                 nconf;
`endif
  for (genvar r = 0; r < NUM_REQ; r++) begin : g_req
    assign nempty[r]     = cnt_q[r] != '0;
    assign reqReady_o[r] = ~reset & (cnt_q[r] != CW'(FIFO_DEPTH));
    assign push[r]       = reqValid_i[r] & reqReady_o[r];
  end
  assign run    = ~reset & ramReady_i & ~ramGated_i;
  assign idle_o = reset | ~|nempty;
  // Scan from rr_q; a head whose address is already claimed this cycle is skipped but the scan continues.
  always_comb begin
    pop      = '0;
    used     = '0;
    np       = 0;
    idx      = 0;
    last     = rr_q;
    addrWr_o = '0;
    dataWr_o = '0;
    wrEn_o   = '0;
`ifdef RAM_WR_SCHED_PERF_EN
    nconf    = 0;
`endif
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_q) + k) % NUM_REQ;
      if (run && nempty[idx] && np < NUM_WR_PORTS) begin
        if (used[addr_q[idx][rp_q[idx]]]) begin
`ifdef RAM_WR_SCHED_PERF_EN
          nconf++;
`endif
        end else begin
          pop[idx]                     = 1'b1;
          used[addr_q[idx][rp_q[idx]]] = 1'b1;
          wrEn_o[np]                   = 1'b1;
          addrWr_o[np]                 = DEPTH'(1) << addr_q[idx][rp_q[idx]];
          dataWr_o[np]                 = data_q[idx][rp_q[idx]];
          last                         = RW'(idx);
          np++;
        end
      end
    end
    rr_d = (np == 0) ? rr_q : (last == RW'(NUM_REQ - 1)) ? '0 : last + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q <= '0;
      for (int r = 0; r < NUM_REQ; r++) begin
        wp_q[r]  <= '0;
        rp_q[r]  <= '0;
        cnt_q[r] <= '0;
      end
    end else begin
      rr_q <= rr_d;
      for (int r = 0; r < NUM_REQ; r++) begin
        if (push[r]) wp_q[r] <= wp_q[r] + 1'b1;
        if (pop[r]) rp_q[r] <= rp_q[r] + 1'b1;
        cnt_q[r] <= cnt_q[r] + CW'(push[r]) - CW'(pop[r]);
      end
    end
  end
  always_ff @(posedge clk) begin
    for (int r = 0; r < NUM_REQ; r++) begin
      if (push[r]) begin
        addr_q[r][wp_q[r]] <= reqAddr_i[r];
        data_q[r][wp_q[r]] <= reqData_i[r];
      end
    end
  end
`ifdef RAM_WR_SCHED_PERF_EN
  function automatic logic [15:0] sat_add(input logic [15:0] a, input int b);
    logic [16:0] s;
    s = {1'b0, a} + 17'(b);
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction
  always_ff @(posedge clk) begin
    if (reset) begin
      grantCnt_o    <= '0;
      stallCnt_o    <= '0;
      conflictCnt_o <= '0;
    end else begin
      grantCnt_o    <= sat_add(grantCnt_o, np);
      stallCnt_o    <= sat_add(stallCnt_o, (|nempty && np == 0) ? 1 : 0);
      conflictCnt_o <= sat_add(conflictCnt_o, nconf);
    end
  end
`endif
endmodule

// File: doc/ram_wr_port_scheduler.md
Name: ram_wr_port_scheduler

Overview:
- Shares the NUM_WR_PORTS write ports of a static one-hot-addressed RAM between NUM_REQ independent write requesters.
- Each requester pushes binary-addressed writes into a private FIFO.
- Each cycle the scheduler grants up to NUM_WR_PORTS FIFO heads, round-robin, and drives one-hot addrWr/dataWr/wrEn directly to the RAM.
- Stalls while the RAM is gated or not ready.

Parameters:
- NUM_REQ, 4, number of write requesters (2..8)
- NUM_WR_PORTS, 2, RAM write ports (1..NUM_REQ)
- DEPTH, 32, RAM entries
- INDEX, 5, log2(DEPTH), width of binary request address
- WIDTH, 32, data width
- FIFO_DEPTH, 4, entries per requester FIFO (power of 2, >=2)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- reqValid_i  in  NUM_REQ  per-requester write valid
- reqAddr_i  in  NUM_REQ x INDEX  binary write address
- reqData_i  in  NUM_REQ x WIDTH  write data
- reqReady_o  out  NUM_REQ  FIFO can accept this cycle
- ramReady_i  in  1  RAM ready (from RAM ramReady_o)
- ramGated_i  in  1  RAM clock gated; no writes allowed
- addrWr_o  out  NUM_WR_PORTS x DEPTH  one-hot write address per port
- dataWr_o  out  NUM_WR_PORTS x WIDTH  write data per port
- wrEn_o  out  NUM_WR_PORTS  write enable per port
- idle_o  out  1  all FIFOs empty

Behaviour:
- Enqueue: push on posedge when reqValid_i[r] & reqReady_o[r]. reqReady_o[r] = ~reset & ~full[r]. No same-cycle push-to-pop bypass: an entry pushed at edge t is eligible for grant in cycle t+1 at the earliest.
- Grant: combinational from FIFO heads. Scan requesters starting at rrPtr, wrapping modulo NUM_REQ. Assign non-empty heads to ports 0,1,... in scan order until ports are exhausted or every requester is scanned.
- Address conflict: a head whose address equals an address already granted this cycle is skipped (not granted, not popped). The scan continues to later requesters.
- Stall: no grants and all wrEn_o = 0 while reset, ~ramReady_i, or ramGated_i is high. FIFOs keep their contents and rrPtr holds.
- Pop: each granted head pops at the same posedge at which the RAM captures the write. Write latency is one cycle minimum from accept to RAM update.
- Ungranted ports: wrEn_o = 0, addrWr_o = 0, dataWr_o = 0.
- addrWr_o[p]: one-hot decode of the granted binary address, exactly one bit set.
- rrPtr update: if at least one grant, rrPtr <= (index of last granted requester + 1) mod NUM_REQ; otherwise unchanged.
- Simultaneous push and pop on the same FIFO: both occur, occupancy unchanged. A full FIFO being popped still reports reqReady_o = 0 that cycle (no full-bypass).
- FIFO pointers: wrap modulo FIFO_DEPTH. Full/empty come from an occupancy count of width log2(FIFO_DEPTH)+1.
- Reset (including mid-operation): on the clocked reset edge all FIFOs empty, rrPtr = 0, and pending writes are discarded. While reset is asserted: wrEn_o = 0, reqReady_o = 0, idle_o = 1.
- idle_o = 1 iff every FIFO is empty.

Optional Feature:
- Macro: RAM_WR_SCHED_PERF_EN.
- When defined, add outputs grantCnt_o[15:0], stallCnt_o[15:0] and conflictCnt_o[15:0]. All three are saturating counters, cleared on reset.
- grantCnt_o counts granted writes, and adds up to NUM_WR_PORTS per cycle.
- stallCnt_o counts cycles with at least one non-empty FIFO and zero grants.
- conflictCnt_o counts heads skipped due to address conflict.
- When the macro is undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Single write:
  - Stimulus: req0 pushes addr 5, data 0xA5A5A5A5 at cycle 1.
  - Response: cycle 2 shows wrEn_o[0] = 1, addrWr_o[0] = 0x00000020, dataWr_o[0] = 0xA5A5A5A5; idle_o = 1 from cycle 3.
- Round-robin fairness:
  - Stimulus: all 4 requesters keep FIFOs non-empty with distinct addresses.
  - Response: grant pairs are {0,1}, {2,3}, {0,1}...; each requester gets exactly 1 write per 2 cycles.
- Address conflict:
  - Stimulus: req1 and req2 heads both target addr 7 in the same cycle, rrPtr = 1.
  - Response: only req1 is granted; port 1 takes req3 if it is non-empty, else stays idle; req2 is granted the next cycle.
- Full/backpressure:
  - Stimulus: hold ramGated_i = 1 and push 4 entries into req0.
  - Response: reqReady_o[0] = 0 after the 4th push and wrEn_o stays 0. Release ramGated_i: 4 writes drain in FIFO order over 4 cycles, and reqReady_o[0] returns to 1 one cycle after the first pop.
- Reset mid-operation:
  - Stimulus: assert reset for 1 cycle with 3 entries queued.
  - Response: the next cycle shows wrEn_o = 0, idle_o = 1, and the queued entries are never written.
- Perf counters (RAM_WR_SCHED_PERF_EN):
  - Stimulus: run the conflict scenario, then hold ramReady_i = 0 for 5 cycles with a non-empty FIFO.
  - Response: conflictCnt_o = 1 and stallCnt_o = 5.
